maxpool2d_stream_size_2: RTL and testbench
==========================================

MAXPOOL2D_STREAM_SIZE_2 -- requirements
Module: maxpool2d_stream_size_2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning IEEE-754 single-precision word width (only 32 supported).
REQ-002 SHALL have parameter IMG_WIDTH, default 56, meaning input pixels per row.
REQ-003 SHALL have parameter IMG_HEIGHT, default 56, meaning input rows per frame.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 valid_in  input  1  data_in carries one conv output pixel this cycle; no backpressure exists.
REQ-007 data_in  input  DATA_WIDTH  float32 pixel, raster order (row-major, column 0 first).
REQ-008 data_out  output  DATA_WIDTH  float32 pooled pixel, registered.
REQ-009 valid_out  output  1  data_out valid this cycle, single-cycle pulse per pooled pixel.
REQ-010 done_out  output  1  pulses high together with the valid_out of the last pooled pixel of a frame.

Function
REQ-011 SHALL perform 2x2 max pooling, stride 2, on each IMG_WIDTH x IMG_HEIGHT frame, producing floor(IMG_WIDTH/2) x floor(IMG_HEIGHT/2) outputs in raster order.
REQ-012 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), advancing only on valid_in; col wraps to 0 and increments row; row wraps to 0 after the last pixel of a frame.
REQ-013 Even col: SHALL store data_in in hold register; odd col: pair = fmax(hold, data_in).
REQ-014 Even row, odd col: SHALL write pair into line buffer entry col>>1 (depth floor(IMG_WIDTH/2)).
REQ-015 Odd row, odd col: SHALL register data_out = fmax(pair, linebuf[col>>1]) and assert valid_out on the next cycle (latency 1 cycle from the fourth window pixel).
REQ-016 fmax SHALL compare as sign-magnitude: larger of two positives by magnitude, smaller magnitude of two negatives, positive beats negative; +0 and -0 equal, first operand returned on tie; NaN/Inf not supported.
REQ-017 Odd IMG_WIDTH: last column of each row SHALL be accepted and discarded. Odd IMG_HEIGHT: last row SHALL be accepted and discarded; no output generated.
REQ-018 done_out SHALL assert with valid_out for output at pooled row floor(IMG_HEIGHT/2)-1, column floor(IMG_WIDTH/2)-1.
REQ-019 Gaps in valid_in (any number of idle cycles between pixels) SHALL not change results; state holds while valid_in low.
REQ-020 Back-to-back frames with valid_in continuously high SHALL be pooled with no lost pixel; frame boundary is counter wrap only.
REQ-021 valid_out and done_out SHALL be low in all cycles not covered by REQ-015/REQ-018; data_out holds last value when valid_out low.

Reset
REQ-022 On resetn low: data_out=0, valid_out=0, done_out=0, col=0, row=0, hold=0, immediately and asynchronously.
REQ-023 Line buffer contents SHALL not require reset; every entry is written in an even row before being read.
REQ-024 Reset mid-frame SHALL abandon the partial frame; the first valid_in after release is pixel (0,0) of a new frame.

Configuration
REQ-025 Macro MAXPOOL_RELU_EN: when defined, the value registered into data_out SHALL be 32'h00000000 if the pooled result sign bit is 1 (including -0), else the pooled result (ReLU fused after pooling).
REQ-026 Without MAXPOOL_RELU_EN, data_out SHALL be the raw pooled result, negatives preserved; no extra latency in either case.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4 unless stated)
REQ-027 Frame of values 1.0..16.0 (row-major), valid_in continuous -> outputs 6.0, 8.0, 14.0, 16.0 on four valid_out pulses, done_out with 16.0, each 1 cycle after pixels 6, 8, 14, 16.
REQ-028 All pixels -1.0..-16.0, macro undefined -> outputs -1.0, -3.0, -9.0, -11.0; macro defined -> four outputs 0x00000000.
REQ-029 Same frame as REQ-027 with 3 idle cycles between every pixel -> identical values and done_out timing relative to the last accepted pixel.
REQ-030 Two frames back-to-back (second = first + 100.0) -> 8 outputs, second set 106.0, 108.0, 114.0, 116.0, done_out pulsed twice.
REQ-031 resetn pulsed low after 7 pixels, then a full REQ-027 frame -> no output from the partial frame; outputs exactly 6.0, 8.0, 14.0, 16.0.
REQ-032 IMG_WIDTH=5, IMG_HEIGHT=5, values 1.0..25.0 -> outputs 7.0, 9.0, 17.0, 19.0; pixels of column 4 and row 4 produce no output; done_out with 19.0.

Source files
------------

// File: rtl/maxpool2d_stream_size_2.sv
// Streaming 2x2/stride-2 float32 max pooling over raster-order frames, one line buffer of pair maxima.
// Optional `define MAXPOOL_RELU_EN fuses a ReLU (sign bit set -> +0) onto the registered result.
module maxpool2d_stream_size_2 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 56,
  parameter int IMG_HEIGHT = 56
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  done_out
);

  localparam int OUT_W = IMG_WIDTH / 2;
  localparam int OUT_H = IMG_HEIGHT / 2;
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [COL_W-1:0] LAST_COL      = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_POOL_COL = COL_W'(2 * OUT_W - 1);
  localparam logic [ROW_W-1:0] LAST_POOL_ROW = ROW_W'(2 * OUT_H - 1);

  // Sign-magnitude maximum; on equality (including +0 vs -0) the first operand wins.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-2:0] ma;
    logic [DATA_WIDTH-2:0] mb;
    logic [DATA_WIDTH-1:0] r;
    ma = a[DATA_WIDTH-2:0];
    mb = b[DATA_WIDTH-2:0];
    r  = a;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
      if ((ma != '0) || (mb != '0)) r = a[DATA_WIDTH-1] ? b : a;
    end else if (!a[DATA_WIDTH-1]) begin
      if (mb > ma) r = b;
    end else begin
      if (mb < ma) r = b;
    end
    return r;
  endfunction

  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_linebuf [OUT_W];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_done_out;

  logic                  w_oddCol;
  logic                  w_oddRow;
  logic                  w_rowInPool;
  logic [LB_W-1:0]       w_lbIdx;
  logic [DATA_WIDTH-1:0] w_pair;
  logic [DATA_WIDTH-1:0] w_pooled;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_lbWrite;
  logic                  w_fireWindow;
  logic                  w_lastWindow;

  assign w_oddCol     = r_col[0];
  assign w_oddRow     = r_row[0];
  // The trailing row of an odd-height frame must not disturb the line buffer.
  assign w_rowInPool  = ((IMG_HEIGHT % 2) == 0) || (r_row != LAST_ROW);
  assign w_lbIdx      = LB_W'(r_col >> 1);
  assign w_pair       = fmax(r_hold, data_in);
  assign w_pooled     = fmax(w_pair, r_linebuf[w_lbIdx]);
  assign w_lbWrite    = valid_in && w_oddCol && !w_oddRow && w_rowInPool;
  assign w_fireWindow = valid_in && w_oddCol && w_oddRow;
  assign w_lastWindow = (r_row == LAST_POOL_ROW) && (r_col == LAST_POOL_COL);

`ifdef MAXPOOL_RELU_EN
  assign w_result = w_pooled[DATA_WIDTH-1] ? '0 : w_pooled;
`else
  assign w_result = w_pooled;
`endif

  // Raster position and even-column hold; the frame boundary is purely the counter wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col  <= '0;
      r_row  <= '0;
      r_hold <= '0;
    end else if (valid_in) begin
      if (!w_oddCol) r_hold <= data_in;
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Every entry is rewritten in an even row before the odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_lbWrite) r_linebuf[w_lbIdx] <= w_pair;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_done_out  <= 1'b0;
    end else if (w_fireWindow) begin
      r_data_out  <= w_result;
      r_valid_out <= 1'b1;
      r_done_out  <= w_lastWindow;
    end else begin
      r_valid_out <= 1'b0;
      r_done_out  <= 1'b0;
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign done_out  = r_done_out;

endmodule

// File: tb/tb_maxpool2d_stream_size_2.sv
// Directed bench for maxpool2d_stream_size_2: a 4x4 instance for most scenarios and a 5x5 instance
// for odd-dimension discard; expected values are hand-derived float32 constants.
module tb_maxpool2d_stream_size_2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        valid4, valid5;
  logic [31:0] data4, data5;
  logic [31:0] out4, out5;
  logic        vout4, vout5, done4, done5;

  maxpool2d_stream_size_2 #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .valid_in(valid4), .data_in(data4),
    .data_out(out4), .valid_out(vout4), .done_out(done4));

  maxpool2d_stream_size_2 #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5)) u_dut5 (
    .clk(clk), .resetn(resetn), .valid_in(valid5), .data_in(data5),
    .data_out(out5), .valid_out(vout5), .done_out(done5));

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] pix [64];
  logic [31:0] expData [16];
  logic        expDone [16];
  int          expCnt  [16];

  int          cyc = 0;
  int          cnt4 = 0, cnt5 = 0, lastAcc4 = 0, lastAcc5 = 0;
  logic [31:0] obsData4 [16];
  logic [31:0] obsData5 [16];
  logic        obsDone4 [16];
  logic        obsDone5 [16];
  int          obsCnt4 [16];
  int          obsCnt5 [16];
  int          obsLag4 [16];
  int          obsLag5 [16];
  int          n4 = 0, n5 = 0, stray4 = 0, stray5 = 0;

  // Build a float32 pattern for a small signed integer.
  function automatic logic [31:0] fp(input int n);
    int m;
    int e;
    logic [31:0] r;
    m = (n < 0) ? -n : n;
    r = '0;
    if (m != 0) begin
      e = 0;
      while ((m >> (e + 1)) != 0) e++;
      r[31]    = (n < 0);
      r[30:23] = 8'(127 + e);
      r[22:0]  = 23'((m << (23 - e)) & 32'h007F_FFFF);
    end
    return r;
  endfunction

  function automatic logic [31:0] post(input logic [31:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  // Accepted-pixel counters and the cycle each was accepted.
  always @(posedge clk) begin
    cyc++;
    if (valid4) begin cnt4++; lastAcc4 = cyc; end
    if (valid5) begin cnt5++; lastAcc5 = cyc; end
  end

  always @(negedge clk) begin
    if (vout4) begin
      if (n4 < 16) begin
        obsData4[n4] = out4; obsDone4[n4] = done4;
        obsCnt4[n4] = cnt4;  obsLag4[n4] = cyc - lastAcc4;
      end
      n4++;
    end
    if (vout5) begin
      if (n5 < 16) begin
        obsData5[n5] = out5; obsDone5[n5] = done5;
        obsCnt5[n5] = cnt5;  obsLag5[n5] = cyc - lastAcc5;
      end
      n5++;
    end
    if (done4 && !vout4) stray4++;
    if (done5 && !vout5) stray5++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearObs();
    n4 = 0; n5 = 0; stray4 = 0; stray5 = 0; cnt4 = 0; cnt5 = 0;
    for (int k = 0; k < 16; k++) begin
      obsData4[k] = '0; obsDone4[k] = 1'b0; obsCnt4[k] = 0; obsLag4[k] = -1;
      obsData5[k] = '0; obsDone5[k] = 1'b0; obsCnt5[k] = 0; obsLag5[k] = -1;
    end
  endtask

  task automatic setExp(input int k, input logic [31:0] d, input logic dn, input int c);
    expData[k] = d; expDone[k] = dn; expCnt[k] = c;
  endtask

  task automatic applyStimulus(input int which, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which == 4) begin valid4 = 1'b1; data4 = pix[i]; end
      else begin valid5 = 1'b1; data5 = pix[i]; end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        valid4 = 1'b0; valid5 = 1'b0;
      end
    end
    @(negedge clk);
    valid4 = 1'b0; valid5 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic checkFrame(input string tag, input int which, input int nExp);
    logic [31:0] d;
    logic        dn;
    int          c, lag;
    checkOutput({tag, "-count"}, 32'((which == 4) ? n4 : n5), 32'(nExp));
    checkOutput({tag, "-strayDone"}, 32'((which == 4) ? stray4 : stray5), 32'd0);
    for (int k = 0; k < nExp; k++) begin
      if (which == 4) begin d = obsData4[k]; dn = obsDone4[k]; c = obsCnt4[k]; lag = obsLag4[k]; end
      else begin d = obsData5[k]; dn = obsDone5[k]; c = obsCnt5[k]; lag = obsLag5[k]; end
      checkOutput($sformatf("%s-data%0d", tag, k), d, expData[k]);
      checkOutput($sformatf("%s-done%0d", tag, k), 32'(dn), 32'(expDone[k]));
      checkOutput($sformatf("%s-pixel%0d", tag, k), 32'(c), 32'(expCnt[k]));
      checkOutput($sformatf("%s-latency%0d", tag, k), 32'(lag), 32'd0);
    end
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput({tag, "-data4"}, out4, 32'h0);
    checkOutput({tag, "-valid4"}, 32'(vout4), 32'h0);
    checkOutput({tag, "-done4"}, 32'(done4), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    clearObs();
  endtask

  task automatic loadRamp4(input int sign, input int offset);
    for (int i = 0; i < 16; i++) pix[i] = fp(sign * (i + 1 + offset));
  endtask

  task automatic expectRamp4(input int offset, input int base, input int cntBase);
    setExp(base + 0, fp(6 + offset), 1'b0, cntBase + 6);
    setExp(base + 1, fp(8 + offset), 1'b0, cntBase + 8);
    setExp(base + 2, fp(14 + offset), 1'b0, cntBase + 14);
    setExp(base + 3, fp(16 + offset), 1'b1, cntBase + 16);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    valid4 = 1'b0; valid5 = 1'b0; data4 = '0; data5 = '0;
    clearObs();
    @(posedge clk);
    #1;
    checkOutput("init-data4", out4, 32'h0);
    checkOutput("init-valid4", 32'(vout4), 32'h0);
    checkOutput("init-done4", 32'(done4), 32'h0);
    checkOutput("init-data5", out5, 32'h0);
    checkOutput("init-valid5", 32'(vout5), 32'h0);
    checkOutput("init-done5", 32'(done5), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    clearObs();

    $display("[TB] ramp frame, continuous");
    loadRamp4(1, 0);
    expectRamp4(0, 0, 0);
    applyStimulus(4, 16, 0);
    checkFrame("ramp", 4, 4);
    doReset("rstAfterRamp");

    $display("[TB] negative ramp frame");
    loadRamp4(-1, 0);
    setExp(0, post(fp(-1)), 1'b0, 6);
    setExp(1, post(fp(-3)), 1'b0, 8);
    setExp(2, post(fp(-9)), 1'b0, 14);
    setExp(3, post(fp(-11)), 1'b1, 16);
    applyStimulus(4, 16, 0);
    checkFrame("neg", 4, 4);
    clearObs();

    $display("[TB] ramp frame with idle gaps");
    loadRamp4(1, 0);
    expectRamp4(0, 0, 0);
    applyStimulus(4, 16, 3);
    checkFrame("gaps", 4, 4);
    clearObs();

    $display("[TB] two frames back to back");
    loadRamp4(1, 0);
    for (int i = 0; i < 16; i++) pix[16 + i] = fp(i + 1 + 100);
    expectRamp4(0, 0, 0);
    expectRamp4(100, 4, 16);
    applyStimulus(4, 32, 0);
    checkFrame("b2b", 4, 8);

    $display("[TB] reset mid-frame then full frame");
    loadRamp4(1, 0);
    applyStimulus(4, 7, 0);
    doReset("rstMidFrame");
    expectRamp4(0, 0, 0);
    applyStimulus(4, 16, 0);
    checkFrame("afterRst", 4, 4);
    clearObs();

    $display("[TB] signed-zero and mixed-sign frame");
    pix[0]  = 32'h0000_0000; pix[1]  = 32'h0000_0000; pix[2]  = fp(-5); pix[3]  = fp(3);
    pix[4]  = 32'h8000_0000; pix[5]  = 32'h8000_0000; pix[6]  = fp(-7); pix[7]  = fp(2);
    pix[8]  = fp(-2);        pix[9]  = fp(-9);        pix[10] = fp(7);  pix[11] = fp(5);
    pix[12] = fp(-8);        pix[13] = fp(-3);        pix[14] = fp(6);  pix[15] = fp(1);
    setExp(0, post(32'h8000_0000), 1'b0, 6);
    setExp(1, fp(3), 1'b0, 8);
    setExp(2, post(fp(-2)), 1'b0, 14);
    setExp(3, fp(7), 1'b1, 16);
    applyStimulus(4, 16, 0);
    checkFrame("mixed", 4, 4);
    clearObs();

    $display("[TB] 5x5 frame, odd dimensions");
    for (int i = 0; i < 25; i++) pix[i] = fp(i + 1);
    setExp(0, fp(7), 1'b0, 7);
    setExp(1, fp(9), 1'b0, 9);
    setExp(2, fp(17), 1'b0, 17);
    setExp(3, fp(19), 1'b1, 19);
    applyStimulus(5, 25, 0);
    checkFrame("odd5", 5, 4);
    checkOutput("odd5-idle4", 32'(n4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
